// File: rtl/io_bridge.sv
// Peripheral-side I/O responder: one-word input buffers read by the core, output registers drained by consumers.
// Optional data-arrival interrupt is built only when the IO_ITR_EN macro is defined.
module io_bridge #(
    parameter int NUBITS = 32,
    parameter int NUIOIN = 8,
    parameter int NUIOOU = 8,
    localparam int AIW = $clog2(NUIOIN),
    localparam int AOW = $clog2(NUIOOU)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_in,
    input  logic [AIW-1:0]           addr_in,
    output logic [NUBITS-1:0]        io_in,
    input  logic                     out_en,
    input  logic [AOW-1:0]           addr_out,
    input  logic [NUBITS-1:0]        data_out,
    input  logic [NUIOIN*NUBITS-1:0] ext_in_data,
    input  logic [NUIOIN-1:0]        ext_in_valid,
    output logic [NUIOIN-1:0]        ext_in_ready,
    output logic [NUIOOU*NUBITS-1:0] ext_out_data,
    output logic [NUIOOU-1:0]        ext_out_valid,
    input  logic [NUIOOU-1:0]        ext_out_ready,
    output logic [NUIOIN-1:0]        underflow,
    output logic [NUIOOU-1:0]        overrun,
    input  logic                     clr_err,
    output logic                     itr
);

    // Handshake: a word moves on any cycle where valid and ready are both high at posedge clk;
    // valid must not depend on ready, and data is held stable while valid is high and not taken.

    logic [NUIOIN-1:0][NUBITS-1:0] hold_q, hold_d;
    logic [NUIOIN-1:0]             full_q, full_d;
    logic [NUIOIN-1:0]             underflow_q, underflow_d;
    logic [NUIOOU-1:0][NUBITS-1:0] out_reg_q, out_reg_d;
    logic [NUIOOU-1:0]             pend_q, pend_d;
    logic [NUIOOU-1:0]             overrun_q, overrun_d;

    logic [NUIOIN-1:0] in_sel, rd_hit, in_acc;
    logic [NUIOOU-1:0] out_sel, wr_hit, drain;

    always_comb begin
        in_sel = '0;
        for (int i = 0; i < NUIOIN; i++) begin
            in_sel[i] = (addr_in == AIW'(i));
        end
        out_sel = '0;
        for (int j = 0; j < NUIOOU; j++) begin
            out_sel[j] = (addr_out == AOW'(j));
        end
    end

    // An out-of-range address selects no channel, so io_in reads as zero.
    always_comb begin
        io_in = '0;
        for (int i = 0; i < NUIOIN; i++) begin
            if (in_sel[i]) begin
                io_in = hold_q[i];
            end
        end
    end

    always_comb begin
        rd_hit      = {NUIOIN{req_in}} & in_sel;
        in_acc      = ext_in_valid & ~full_q;
        full_d      = (full_q & ~rd_hit) | in_acc;
        underflow_d = (underflow_q & {NUIOIN{~clr_err}}) | (rd_hit & ~full_q);
        hold_d      = hold_q;
        for (int i = 0; i < NUIOIN; i++) begin
            if (in_acc[i]) begin
                hold_d[i] = ext_in_data[i*NUBITS +: NUBITS];
            end
        end
    end

    // Write and drain in the same cycle: the consumer takes the old word and pend stays set.
    always_comb begin
        wr_hit    = {NUIOOU{out_en}} & out_sel;
        drain     = pend_q & ext_out_ready;
        pend_d    = wr_hit | (pend_q & ~drain);
        overrun_d = (overrun_q & {NUIOOU{~clr_err}}) | (wr_hit & pend_q & ~drain);
        out_reg_d = out_reg_q;
        for (int j = 0; j < NUIOOU; j++) begin
            if (wr_hit[j]) begin
                out_reg_d[j] = data_out;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q      <= '0;
            full_q      <= '0;
            underflow_q <= '0;
            out_reg_q   <= '0;
            pend_q      <= '0;
            overrun_q   <= '0;
        end else begin
            hold_q      <= hold_d;
            full_q      <= full_d;
            underflow_q <= underflow_d;
            out_reg_q   <= out_reg_d;
            pend_q      <= pend_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef IO_ITR_EN
    logic itr_q, itr_d;

    // One pulse, aligned with the first cycle full is high, however many channels filled.
    always_comb begin
        itr_d = |(full_d & ~full_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            itr_q <= 1'b0;
        end else begin
            itr_q <= itr_d;
        end
    end

    assign itr = itr_q;
`else
    assign itr = 1'b0;
`endif

    assign ext_in_ready  = ~full_q;
    assign ext_out_data  = out_reg_q;
    assign ext_out_valid = pend_q;
    assign underflow     = underflow_q;
    assign overrun       = overrun_q;

endmodule
